// File: rtl/draw_result_banner.sv
// draw_result_banner: end-of-round banner overlay for the VGA chain.
// Draws WIN / LOSE / DRAW from an internal 8x8 glyph ROM, replicated by SCALE,
// with its top-left corner at (XPOS,YPOS). An optional backdrop box of
// BOX_RGB extends MARGIN pixels around the text. The message is latched only
// at frame boundaries (rising vsync). A blink phase can run before the banner
// is shown steadily.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   state[2:0]               game state: 3=WIN, 4=LOSE, 5=DRAW, other=no banner
//   vga_result_in_*          upstream hcount/hsync/hblnk/vcount/vsync/vblnk/rgb
//   vga_result_out_*         the same fields delayed 2 clk, rgb with overlay
//
// FSM states:
//   state  | meaning
//   IDLE   | no message latched, rgb passes through
//   BLINK  | message shown, visibility toggles every BLINK_FR frames
//   STEADY | message shown continuously
module draw_result_banner #(
  parameter int          XPOS      = 600,
  parameter int          YPOS      = 334,
  parameter int          SCALE     = 8,
  parameter logic [11:0] WIN_RGB   = 12'hfa5,
  parameter logic [11:0] LOSE_RGB  = 12'hfa5,
  parameter logic [11:0] DRAW_RGB  = 12'hfa5,
  parameter bit          BOX_EN    = 1'b1,
  parameter logic [11:0] BOX_RGB   = 12'h000,
  parameter int          MARGIN    = 8,
  parameter int          BLINK_FR  = 15,
  parameter int          BLINK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [10:0] vga_result_in_hcount,
  input  logic        vga_result_in_hsync,
  input  logic        vga_result_in_hblnk,
  input  logic [10:0] vga_result_in_vcount,
  input  logic        vga_result_in_vsync,
  input  logic        vga_result_in_vblnk,
  input  logic [11:0] vga_result_in_rgb,
  output logic [10:0] vga_result_out_hcount,
  output logic        vga_result_out_hsync,
  output logic        vga_result_out_hblnk,
  output logic [10:0] vga_result_out_vcount,
  output logic        vga_result_out_vsync,
  output logic        vga_result_out_vblnk,
  output logic [11:0] vga_result_out_rgb
);

  localparam int LOG2S = $clog2(SCALE);
  localparam int PITCH = 9 * SCALE;

  localparam logic signed [11:0] XPOS_S   = 12'(XPOS);
  localparam logic signed [11:0] YPOS_S   = 12'(YPOS);
  localparam logic signed [11:0] PITCH1   = 12'(PITCH);
  localparam logic signed [11:0] PITCH2   = 12'(2 * PITCH);
  localparam logic signed [11:0] PITCH3   = 12'(3 * PITCH);
  localparam logic signed [11:0] GLYPH_W  = 12'(8 * SCALE);
  localparam logic signed [11:0] TEXT_H   = 12'(8 * SCALE);
  localparam logic signed [11:0] W3       = 12'(3 * PITCH - SCALE);
  localparam logic signed [11:0] W4       = 12'(4 * PITCH - SCALE);
  localparam logic signed [11:0] MARGIN_S = 12'(MARGIN);
  localparam logic signed [11:0] BOX_LO   = 12'(-MARGIN);
  localparam logic signed [11:0] BOX_HI_Y = 12'(8 * SCALE + MARGIN);

  localparam int FR_W = (BLINK_FR > 2) ? $clog2(BLINK_FR) : 1;
  localparam int TG_W = (BLINK_CNT > 0) ? $clog2(2 * BLINK_CNT) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'((BLINK_FR > 0) ? BLINK_FR - 1 : 0);
  localparam logic [TG_W-1:0] TG_LAST = TG_W'((BLINK_CNT > 0) ? 2 * BLINK_CNT - 1 : 0);
  localparam bit BLINK_ON = (BLINK_FR > 0) && (BLINK_CNT > 0);

  typedef enum logic [1:0] {MSG_NONE, MSG_WIN, MSG_LOSE, MSG_DRAW} msg_t;
  typedef enum logic [1:0] {IDLE, BLINK, STEADY} fsm_t;
  typedef enum logic [3:0] {G_W, G_I, G_N, G_L, G_O, G_S, G_E, G_D, G_R, G_A} glyph_t;

  // Row 0 is the top byte; bit 7 of each row is the leftmost column.
  function automatic logic [7:0] glyph_row(input glyph_t g, input logic [2:0] row);
    logic [63:0] rows;
    case (g)
      G_W:     rows = 64'hC6C6C6D6FEEEC600;
      G_I:     rows = 64'h3C18181818183C00;
      G_N:     rows = 64'hC6E6F6DECEC6C600;
      G_L:     rows = 64'hC0C0C0C0C0C0FE00;
      G_O:     rows = 64'h7CC6C6C6C6C67C00;
      G_S:     rows = 64'h7CC6C07C06C67C00;
      G_E:     rows = 64'hFEC0C0FCC0C0FE00;
      G_D:     rows = 64'hF8CCC6C6C6CCF800;
      G_R:     rows = 64'hFCC6C6FCD8CCC600;
      G_A:     rows = 64'h386CC6C6FEC6C600;
      default: rows = '0;
    endcase
    return rows[{3'd7 - row, 3'b000} +: 8];
  endfunction

  function automatic glyph_t msg_glyph(input msg_t m, input logic [1:0] idx);
    glyph_t g;
    g = G_W;
    case (m)
      MSG_WIN:  case (idx) 2'd0: g = G_W; 2'd1: g = G_I; default: g = G_N; endcase
      MSG_LOSE: case (idx) 2'd0: g = G_L; 2'd1: g = G_O; 2'd2: g = G_S; default: g = G_E; endcase
      MSG_DRAW: case (idx) 2'd0: g = G_D; 2'd1: g = G_R; 2'd2: g = G_A; default: g = G_W; endcase
      default:  g = G_W;
    endcase
    return g;
  endfunction

  function automatic logic [11:0] msg_rgb(input msg_t m);
    case (m)
      MSG_WIN:  return WIN_RGB;
      MSG_LOSE: return LOSE_RGB;
      default:  return DRAW_RGB;
    endcase
  endfunction

  // Frame boundary detect and message latch
  logic vsync_d;
  logic frame_tick;
  msg_t msg_latch;

  assign frame_tick = vga_result_in_vsync & ~vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      msg_latch <= MSG_NONE;
    end else begin
      vsync_d <= vga_result_in_vsync;
      if (frame_tick) begin
        case (state)
          3'd3:    msg_latch <= MSG_WIN;
          3'd4:    msg_latch <= MSG_LOSE;
          3'd5:    msg_latch <= MSG_DRAW;
          default: msg_latch <= MSG_NONE;
        endcase
      end
    end
  end

  // Blink FSM
  fsm_t fsm_q, fsm_d;
  logic [FR_W-1:0] fr_cnt_q, fr_cnt_d;
  logic [TG_W-1:0] tg_cnt_q, tg_cnt_d;
  logic vis_q, vis_d;
  msg_t shown_q, shown_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      fr_cnt_q <= '0;
      tg_cnt_q <= '0;
      vis_q    <= 1'b0;
      shown_q  <= MSG_NONE;
    end else begin
      fsm_q    <= fsm_d;
      fr_cnt_q <= fr_cnt_d;
      tg_cnt_q <= tg_cnt_d;
      vis_q    <= vis_d;
      shown_q  <= shown_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    fr_cnt_d = fr_cnt_q;
    tg_cnt_d = tg_cnt_q;
    vis_d    = vis_q;
    shown_d  = shown_q;
    if (msg_latch == MSG_NONE) begin
      fsm_d    = IDLE;
      fr_cnt_d = '0;
      tg_cnt_d = '0;
      vis_d    = 1'b0;
      shown_d  = MSG_NONE;
    end else if (fsm_q == IDLE || msg_latch != shown_q) begin
      // New message: always start visible, blink phase counted from scratch.
      fsm_d    = BLINK_ON ? BLINK : STEADY;
      fr_cnt_d = '0;
      tg_cnt_d = '0;
      vis_d    = 1'b1;
      shown_d  = msg_latch;
    end else if (fsm_q == BLINK && frame_tick) begin
      if (fr_cnt_q == FR_LAST) begin
        fr_cnt_d = '0;
        if (tg_cnt_q == TG_LAST) begin
          fsm_d    = STEADY;
          vis_d    = 1'b1;
          tg_cnt_d = '0;
        end else begin
          vis_d    = ~vis_q;
          tg_cnt_d = tg_cnt_q + 1'b1;
        end
      end else begin
        fr_cnt_d = fr_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: relative coordinates, glyph select, region flags
  logic signed [11:0] rx, ry, col_off, w_px;
  logic [1:0] idx;
  logic in_text, in_box;

  always_comb begin
    rx      = $signed({1'b0, vga_result_in_hcount}) - XPOS_S;
    ry      = $signed({1'b0, vga_result_in_vcount}) - YPOS_S;
    w_px    = (shown_q == MSG_WIN) ? W3 : W4;
    idx     = 2'd0;
    col_off = rx;
    // Character index by comparing against pitch multiples instead of dividing.
    if (rx < PITCH1) begin
      idx     = 2'd0;
      col_off = rx;
    end else if (rx < PITCH2) begin
      idx     = 2'd1;
      col_off = rx - PITCH1;
    end else if (rx < PITCH3) begin
      idx     = 2'd2;
      col_off = rx - PITCH2;
    end else begin
      idx     = 2'd3;
      col_off = rx - PITCH3;
    end
    in_text = !rx[11] && (rx < w_px) && !ry[11] && (ry < TEXT_H) && (col_off < GLYPH_W);
    in_box  = BOX_EN && (rx >= BOX_LO) && (rx < w_px + MARGIN_S)
              && (ry >= BOX_LO) && (ry < BOX_HI_Y);
  end

  logic [10:0] s1_hcount, s1_vcount;
  logic s1_hsync, s1_hblnk, s1_vsync, s1_vblnk;
  logic [11:0] s1_rgb;
  logic s1_text, s1_box;
  glyph_t s1_glyph;
  logic [2:0] s1_row, s1_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_rgb    <= '0;
      s1_text   <= 1'b0;
      s1_box    <= 1'b0;
      s1_glyph  <= G_W;
      s1_row    <= '0;
      s1_col    <= '0;
    end else begin
      s1_hcount <= vga_result_in_hcount;
      s1_vcount <= vga_result_in_vcount;
      s1_hsync  <= vga_result_in_hsync;
      s1_hblnk  <= vga_result_in_hblnk;
      s1_vsync  <= vga_result_in_vsync;
      s1_vblnk  <= vga_result_in_vblnk;
      s1_rgb    <= vga_result_in_rgb;
      s1_text   <= in_text;
      s1_box    <= in_box;
      s1_glyph  <= msg_glyph(shown_q, idx);
      s1_row    <= ry[LOG2S +: 3];
      s1_col    <= col_off[LOG2S +: 3];
    end
  end

  // Stage 2: glyph lookup and colour mux
  logic glyph_bit;
  logic [11:0] rgb_nxt;

  always_comb begin
    glyph_bit = glyph_row(s1_glyph, s1_row)[3'd7 - s1_col];
    rgb_nxt   = s1_rgb;
    if (s1_hblnk || s1_vblnk || fsm_q == IDLE || !vis_q) begin
      rgb_nxt = s1_rgb;
    end else if (s1_text && glyph_bit) begin
      rgb_nxt = msg_rgb(shown_q);
    end else if (s1_box) begin
      rgb_nxt = BOX_RGB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_result_out_hcount <= '0;
      vga_result_out_hsync  <= 1'b0;
      vga_result_out_hblnk  <= 1'b0;
      vga_result_out_vcount <= '0;
      vga_result_out_vsync  <= 1'b0;
      vga_result_out_vblnk  <= 1'b0;
      vga_result_out_rgb    <= '0;
    end else begin
      vga_result_out_hcount <= s1_hcount;
      vga_result_out_hsync  <= s1_hsync;
      vga_result_out_hblnk  <= s1_hblnk;
      vga_result_out_vcount <= s1_vcount;
      vga_result_out_vsync  <= s1_vsync;
      vga_result_out_vblnk  <= s1_vblnk;
      vga_result_out_rgb    <= rgb_nxt;
    end
  end

endmodule
